// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy engine: reads one source byte, then writes it to the destination.
// Two cycles per byte; addresses wrap modulo 256.
module mem_copy_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic       busy,
    output logic       done,
    output logic [7:0] bytes_done,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_write,
    output logic       mem_read,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] src_q, dst_q, len_q;
    logic [7:0] idx_q;
    logic [7:0] buf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= 8'h00;
            dst_q   <= 8'h00;
            len_q   <= 8'h00;
            idx_q   <= 8'h00;
            buf_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= length;
                        idx_q <= 8'h00;
                    end
                end
                StRead:  buf_q <= mem_rdata;
                StWrite: idx_q <= idx_q + 8'd1;
                default: ;
            endcase
        end
    end

    // The byte index doubles as the bytes-written count; it holds after DONE.
    assign bytes_done = idx_q;

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (length == 8'h00) ? StDone : StRead;
                end
            end
            StRead: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = src_q + idx_q;
                state_d  = StWrite;
            end
            StWrite: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_q + idx_q;
                mem_wdata = buf_q;
                state_d   = ((idx_q + 8'd1) == len_q) ? StDone : StRead;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed scenarios plus random copies,
// compared against an array-based reference memory.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr, dst_addr, length;
    logic       busy, done;
    logic [7:0] bytes_done, mem_addr, mem_wdata, mem_rdata;
    logic       mem_write, mem_read;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bytes_done (bytes_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] = mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) begin
            mem[a]     = 8'($urandom);
            ref_mem[a] = mem[a];
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Ascending byte-by-byte copy; overlapping ranges propagate naturally.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] sa, da;
        sa = s;
        da = d;
        for (int j = 0; j < n; j++) begin
            ref_mem[da] = ref_mem[sa];
            sa = sa + 8'd1;
            da = da + 8'd1;
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 256; a++) check_eq(tag, {24'h0, mem[a]}, {24'h0, ref_mem[a]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check_eq({tag, "_done"}, {31'h0, done}, 32'h0);
        check_eq({tag, "_rd"}, {31'h0, mem_read}, 32'h0);
        check_eq({tag, "_wr"}, {31'h0, mem_write}, 32'h0);
        check_eq({tag, "_addr"}, {24'h0, mem_addr}, 32'h0);
        check_eq({tag, "_wdata"}, {24'h0, mem_wdata}, 32'h0);
    endtask

    // Start a copy and watch it to completion; optionally fire a stray start at cycle inject_at.
    task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input int inject_at);
        int n, done_at, pulses;
        n       = int'(l);
        done_at = -1;
        pulses  = 0;
        model_copy(s, d, n);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = l;
        @(posedge clk);
        @(negedge clk);
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        length   = 8'($urandom);
        for (int m = 0; m < 2 * n + 4; m++) begin
            start = (m == inject_at);
            check_eq({tag, "_rw_excl"}, {31'h0, mem_read & mem_write}, 32'h0);
            check_eq({tag, "_busy"}, {31'h0, busy}, {31'h0, (m < 2 * n)});
            check_eq({tag, "_memact"}, {31'h0, mem_read | mem_write}, {31'h0, (m < 2 * n)});
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = m;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq({tag, "_done_at"}, done_at, 2 * n);
        check_eq({tag, "_pulses"}, pulses, 32'd1);
        check_eq({tag, "_bytes_done"}, {24'h0, bytes_done}, {24'h0, l});
        check_idle_outputs({tag, "_idle"});
        check_mem({tag, "_mem"});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 8'h00;
        fill_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_bytes_done", {24'h0, bytes_done}, 32'h0);
        reset = 1'b0;

        // Basic copy
        poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
        run_copy("basic", 8'h10, 8'h40, 8'd4, -1);
        repeat (3) @(negedge clk);
        check_eq("bytes_done_hold", {24'h0, bytes_done}, 32'd4);

        // Zero length
        run_copy("zero", 8'h33, 8'h77, 8'd0, -1);
        check_eq("zero_bytes_done", {24'h0, bytes_done}, 32'd0);

        // Address wrap
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
        run_copy("wrap", 8'hFE, 8'h80, 8'd3, -1);

        // Start while busy is ignored
        run_copy("busy_start", 8'h60, 8'hA0, 8'd5, 3);

        // Overlapping ranges
        poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
        run_copy("overlap", 8'h20, 8'h21, 8'd3, -1);

        // Reset wins over start in the same cycle
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        length = 8'd5;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_prio");

        // Reset mid-copy, asserted in the cycle after the third write
        model_copy(8'h50, 8'h90, 3);
        @(negedge clk);
        start    = 1'b1;
        src_addr = 8'h50;
        dst_addr = 8'h90;
        length   = 8'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        check_eq("abort_bytes_done", {24'h0, bytes_done}, 32'h0);
        reset = 1'b0;
        for (int m = 0; m < 20; m++) begin
            @(negedge clk);
            check_eq("abort_no_done", {31'h0, done}, 32'h0);
            check_eq("abort_no_write", {31'h0, mem_write}, 32'h0);
        end
        check_mem("abort_mem");

        // Random copies
        for (int t = 0; t < 10; t++) begin
            fill_random();
            run_copy("rand", 8'($urandom), 8'($urandom), 8'($urandom_range(0, 40)), -1);
        end
        fill_random();
        run_copy("rand_long", 8'($urandom), 8'($urandom), 8'd255, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have no parameters; all address and data widths are fixed at 8 bits.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 src_addr  input  8  first source byte address; latched on accepted start.
REQ-007 dst_addr  input  8  first destination byte address; latched on accepted start.
REQ-008 length  input  8  byte count 0..255; latched on accepted start.
REQ-009 busy  output  1  high while in READ or WRITE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 bytes_done  output  8  bytes written so far in the current or last copy.
REQ-012 mem_addr  output  8  data memory address.
REQ-013 mem_wdata  output  8  data memory write data.
REQ-014 mem_write  output  1  data memory write enable; memory commits on the clk edge.
REQ-015 mem_read  output  1  data memory read enable.
REQ-016 mem_rdata  input  8  data memory read data; combinational from mem_addr when mem_read=1.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-018 IDLE transitions:
- start=1 and length!=0 -> READ.
- start=1 and length=0 -> DONE.
- Otherwise stay in IDLE.
REQ-019 On an accepted start, SHALL latch src, dst and length, and clear the index i and bytes_done to 0.
REQ-020 READ: mem_read=1, mem_write=0, mem_addr=src+i (mod 256); SHALL capture mem_rdata into an internal byte buffer at the clk edge; next state WRITE.
REQ-021 WRITE: mem_write=1, mem_read=0, mem_addr=dst+i (mod 256), mem_wdata=buffer; at the clk edge SHALL increment i and bytes_done.
REQ-022 WRITE next state: DONE if i+1==length, else READ.
REQ-023 DONE: done=1 for exactly one cycle, mem_read=0, mem_write=0; next state IDLE.
REQ-024 In IDLE and DONE, mem_addr and mem_wdata SHALL be 0.
REQ-025 mem_read and mem_write SHALL never be high in the same cycle.
REQ-026 Throughput: 2 cycles per byte. With start accepted at edge k, done is high in the cycle after edge k+2N (N=length).
REQ-027 Address arithmetic SHALL wrap modulo 256 (e.g. 0xFF+1=0x00); wrap is not an error.
REQ-028 start SHALL be ignored outside IDLE, and latched inputs SHALL be unaffected by input changes during a copy.
REQ-029 Overlapping ranges SHALL be copied in ascending order, byte by byte, with no overlap correction.
REQ-030 bytes_done SHALL hold its final value until the next accepted start or reset.

Reset
REQ-031 reset=1 at a clk edge SHALL force:
- state IDLE;
- busy=0, done=0, bytes_done=0;
- mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0;
- buffer=0, i=0.
REQ-032 Reset during READ or WRITE SHALL abort the copy: no memory write occurs in the cycle after reset, and no done pulse is produced.
REQ-033 Bytes already written before reset SHALL remain in memory.
REQ-034 reset SHALL take priority over start in the same cycle.

Verification
REQ-035 Basic copy: mem[0x10..0x13]=AA,BB,CC,DD; start with src=0x10, dst=0x40, len=4 -> mem[0x40..0x43]=AA,BB,CC,DD; done pulses exactly 8 cycles after the start edge; bytes_done=4.
REQ-036 Zero length: start with len=0 -> done pulses the next cycle; busy never high; no mem_read or mem_write.
REQ-037 Wrap: mem[0xFE]=11, mem[0xFF]=22, mem[0x00]=33; src=0xFE, dst=0x80, len=3 -> mem[0x80..0x82]=11,22,33.
REQ-038 Busy start: a second start with different args during a copy -> ignored; the first copy completes unchanged with a single done pulse.
REQ-039 Reset mid-copy: len=8, reset asserted in the cycle after the 3rd write -> memory shows 3 destination bytes written, the 4th byte untouched, no done pulse, and all outputs 0 the cycle after reset.
REQ-040 Overlap: mem[0x20..0x22]=1,2,3; src=0x20, dst=0x21, len=3 -> mem[0x21..0x23]=1,1,1 (ascending propagation).
